// File: rtl/tcpdump_csr_pkg.sv
// Shared definitions for the tcpdump capture CSR bank: register offsets,
// bit positions inside CONTROL/STATUS/IRQ registers and the descriptor record.
package tcpdump_csr_pkg;

    // Word offsets of the register map
    typedef enum logic [2:0] {
        CSR_CONTROL   = 3'd0,
        CSR_STATUS    = 3'd1,
        CSR_DESC_ADDR = 3'd2,
        CSR_DESC_LEN  = 3'd3,
        CSR_IRQ_STAT  = 3'd4,
        CSR_IRQ_MASK  = 3'd5,
        CSR_PKT_CNT   = 3'd6,
        CSR_DROP_CNT  = 3'd7
    } csr_off_e;

    // CONTROL bits
    localparam int CTRL_ENABLE    = 0;
    localparam int CTRL_FLUSH     = 1;

    // STATUS fields
    localparam int STAT_STATE_LSB = 0;
    localparam int STAT_FULL      = 2;
    localparam int STAT_EMPTY     = 3;
    localparam int STAT_COUNT_LSB = 8;

    // IRQ_STAT / IRQ_MASK bits
    localparam int IRQ_PKT_DONE   = 0;
    localparam int IRQ_OVERFLOW   = 1;
    localparam int IRQ_DRAINED    = 2;
    localparam int IRQ_W          = 3;

    // Descriptor word width; matches the default CSR data width
    localparam int DESC_W         = 32;

    typedef struct packed {
        logic [DESC_W-1:0] addr;
        logic [DESC_W-1:0] len;
    } desc_t;

endpackage

// File: rtl/tcpdump_csr_if.sv
// Driver-side CSR bus of the capture engine (lightweight HPS bridge).
// master = bridge/driver, slave = CSR bank.
interface tcpdump_csr_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (output address, output read, output write, output writedata, input readdata);
    modport slave  (input address, input read, input write, input writedata, output readdata);
endinterface

// File: rtl/tcpdump_desc_fifo.sv
// Descriptor queue: circular buffer of NUM_DESC entries (power of two).
// Full/empty come from the pre-edge count; a flush cycle discards both the
// push and the pop and returns pointers and count to zero.
module tcpdump_desc_fifo
    import tcpdump_csr_pkg::*;
#(
    parameter  int NUM_DESC = 4,
    localparam int PTR_W    = $clog2(NUM_DESC),
    localparam int FILL_W   = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  desc_t             din,
    output desc_t             head,
    output logic              full,
    output logic              empty,
    output logic [FILL_W-1:0] count,
    output logic              overflow,
    output logic              drained
);

    desc_t             mem_q [NUM_DESC];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0] count_q, count_d;
    logic              do_push, do_pop;

    assign full  = (count_q == FILL_W'(NUM_DESC));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Accept/reject decisions and next pointer/count values
    always_comb begin
        do_push  = push && !full && !flush;
        do_pop   = pop && !empty && !flush;
        overflow = push && full && !flush;
        drained  = do_pop && !do_push && (count_q == FILL_W'(1));
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_d = count_q + FILL_W'(1);
            else if (!do_push && do_pop) count_d = count_q - FILL_W'(1);
        end
    end

    // Pointer and fill-count registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are meaningless while the queue is empty
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/tcpdump_csr.sv
// CSR bank between the HPS lightweight bridge and the capture/DMA engine:
// control, status, descriptor queue front-end, W1C interrupts with mask.
// Optional PKT_CNT/DROP_CNT statistics are built when TCPDUMP_CSR_STATS_EN
// is defined; otherwise offsets 6 and 7 read as zero.
module tcpdump_csr
    import tcpdump_csr_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 3,
    parameter int NUM_DESC = 4,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    tcpdump_csr_if.slave      bus,
    input  logic [1:0]        state,
    output logic              desc_valid,
    input  logic              desc_ready,
    output logic [DATA_W-1:0] desc_addr,
    output logic [DATA_W-1:0] desc_len,
    input  logic              pkt_done,
    output logic              enable,
    output logic              irq
);

    localparam int FILL_W = $clog2(NUM_DESC) + 1;

    logic              enable_q, flush_q;
    logic [1:0]        state_q;
    logic [DATA_W-1:0] desc_addr_q;
    logic [DATA_W-1:0] readdata_q, rdata_d;
    logic [IRQ_W-1:0]  irq_stat_q, irq_stat_d, irq_mask_q, irq_mask_d;
    logic [IRQ_W-1:0]  irq_set, irq_clr;
    logic              irq_q, irq_d;

    logic              wr_ctrl, wr_addr, wr_len, wr_stat, wr_mask;
    logic              q_full, q_empty, q_overflow, q_drained;
    logic [FILL_W-1:0] q_count;
    desc_t             push_desc, head_desc;

    assign wr_ctrl = bus.write && (bus.address == ADDR_W'(CSR_CONTROL));
    assign wr_addr = bus.write && (bus.address == ADDR_W'(CSR_DESC_ADDR));
    assign wr_len  = bus.write && (bus.address == ADDR_W'(CSR_DESC_LEN));
    assign wr_stat = bus.write && (bus.address == ADDR_W'(CSR_IRQ_STAT));
    assign wr_mask = bus.write && (bus.address == ADDR_W'(CSR_IRQ_MASK));

    assign push_desc = '{addr: desc_addr_q, len: bus.writedata};

    tcpdump_desc_fifo #(.NUM_DESC(NUM_DESC)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (wr_len),
        .pop      (desc_valid && desc_ready),
        .flush    (flush_q),
        .din      (push_desc),
        .head     (head_desc),
        .full     (q_full),
        .empty    (q_empty),
        .count    (q_count),
        .overflow (q_overflow),
        .drained  (q_drained)
    );

    assign desc_valid   = !q_empty;
    assign desc_addr    = head_desc.addr;
    assign desc_len     = head_desc.len;
    assign enable       = enable_q;
    assign irq          = irq_q;
    assign bus.readdata = readdata_q;

    // Interrupt status: hardware set beats a coincident write-1-to-clear
    assign irq_set[IRQ_PKT_DONE] = pkt_done;
    assign irq_set[IRQ_OVERFLOW] = q_overflow;
    assign irq_set[IRQ_DRAINED]  = q_drained;
    assign irq_clr    = wr_stat ? bus.writedata[IRQ_W-1:0] : '0;
    assign irq_mask_d = wr_mask ? bus.writedata[IRQ_W-1:0] : irq_mask_q;

    genvar gi;
    generate
        for (gi = 0; gi < IRQ_W; gi++) begin : g_irq_bit
            assign irq_stat_d[gi] = irq_set[gi] | (irq_stat_q[gi] & ~irq_clr[gi]);
        end
    endgenerate

    // irq follows the status/mask that become visible at the same edge
    assign irq_d = |(irq_stat_d & irq_mask_d);

    // Control, staging, engine-state mirror and interrupt registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_q    <= 1'b0;
            flush_q     <= 1'b0;
            state_q     <= '0;
            desc_addr_q <= '0;
            irq_stat_q  <= '0;
            irq_mask_q  <= '0;
            irq_q       <= 1'b0;
        end else begin
            state_q    <= state;
            flush_q    <= wr_ctrl && bus.writedata[CTRL_FLUSH];
            irq_stat_q <= irq_stat_d;
            irq_mask_q <= irq_mask_d;
            irq_q      <= irq_d;
            if (wr_ctrl) enable_q    <= bus.writedata[CTRL_ENABLE];
            if (wr_addr) desc_addr_q <= bus.writedata;
        end
    end

`ifdef TCPDUMP_CSR_STATS_EN
    logic             wr_pkt, wr_drop;
    logic [CNT_W-1:0] pkt_cnt_q, drop_cnt_q;

    assign wr_pkt  = bus.write && (bus.address == ADDR_W'(CSR_PKT_CNT));
    assign wr_drop = bus.write && (bus.address == ADDR_W'(CSR_DROP_CNT));

    // Saturating statistics; a write to the offset clears it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (wr_pkt)                                 pkt_cnt_q <= '0;
            else if (pkt_done && (pkt_cnt_q != '1))     pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
            if (wr_drop)                                drop_cnt_q <= '0;
            else if (q_overflow && (drop_cnt_q != '1))  drop_cnt_q <= drop_cnt_q + CNT_W'(1);
        end
    end
`endif

    // Read mux over pre-edge register values
    always_comb begin
        rdata_d = '0;
        case (bus.address)
            ADDR_W'(CSR_CONTROL):   rdata_d[CTRL_ENABLE] = enable_q;
            ADDR_W'(CSR_STATUS): begin
                rdata_d[STAT_STATE_LSB +: 2]      = state_q;
                rdata_d[STAT_FULL]                = q_full;
                rdata_d[STAT_EMPTY]               = q_empty;
                rdata_d[STAT_COUNT_LSB +: FILL_W] = q_count;
            end
            ADDR_W'(CSR_DESC_ADDR): rdata_d = desc_addr_q;
            ADDR_W'(CSR_IRQ_STAT):  rdata_d[IRQ_W-1:0] = irq_stat_q;
            ADDR_W'(CSR_IRQ_MASK):  rdata_d[IRQ_W-1:0] = irq_mask_q;
`ifdef TCPDUMP_CSR_STATS_EN
            ADDR_W'(CSR_PKT_CNT):   rdata_d[CNT_W-1:0] = pkt_cnt_q;
            ADDR_W'(CSR_DROP_CNT):  rdata_d[CNT_W-1:0] = drop_cnt_q;
`endif
            default:                rdata_d = '0;
        endcase
    end

    // Read data register; holds until the next read strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         readdata_q <= '0;
        else if (bus.read) readdata_q <= rdata_d;
    end

endmodule

// File: tb/tb_tcpdump_csr.sv
// Self-checking bench for tcpdump_csr: register table, directed corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_tcpdump_csr;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  state = 2'd0;
    logic        desc_ready = 1'b0;
    logic        pkt_done = 1'b0;
    logic        desc_valid, enable, irq;
    logic [31:0] desc_addr, desc_len;

    tcpdump_csr_if #(.DATA_W(32), .ADDR_W(3)) bus ();

    tcpdump_csr #(.DATA_W(32), .ADDR_W(3), .NUM_DESC(4), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .state      (state),
        .desc_valid (desc_valid),
        .desc_ready (desc_ready),
        .desc_addr  (desc_addr),
        .desc_len   (desc_len),
        .pkt_done   (pkt_done),
        .enable     (enable),
        .irq        (irq)
    );

    always #5 clk = ~clk;

`ifdef TCPDUMP_CSR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // All bus tasks start and end at a falling edge
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bus.address = a; bus.writedata = d; bus.write = 1'b1; bus.read = 1'b0;
        @(negedge clk);
        bus.write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        bus.address = a; bus.read = 1'b1; bus.write = 1'b0;
        @(negedge clk);
        bus.read = 1'b0;
        d = bus.readdata;
    endtask

    task automatic read_check(input string name, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1; pkt_done = 1'b0; desc_ready = 1'b0; state = 2'd0;
        bus.read = 1'b0; bus.write = 1'b0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [31:0] addr; logic [31:0] len; } mdesc_t;
    mdesc_t      mq[$];
    logic        m_enable, m_flush_pend, m_irq;
    logic [1:0]  m_state;
    logic [31:0] m_daddr, m_rd;
    logic [2:0]  m_stat, m_mask;
    int          m_pkt, m_drop;

    task automatic m_reset();
        mq.delete();
        m_enable = 0; m_flush_pend = 0; m_irq = 0; m_state = 0;
        m_daddr = 0; m_rd = 0; m_stat = 0; m_mask = 0; m_pkt = 0; m_drop = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [2:0] a);
        logic [31:0] r;
        r = 32'd0;
        case (a)
            3'd0: r[0] = m_enable;
            3'd1: begin
                r = 32'(mq.size()) << 8;
                if (mq.size() == 0) r[3] = 1'b1;
                if (mq.size() == 4) r[2] = 1'b1;
                r[1:0] = m_state;
            end
            3'd2: r = m_daddr;
            3'd4: r[2:0] = m_stat;
            3'd5: r[2:0] = m_mask;
            3'd6: r = STATS ? 32'(m_pkt) : 32'd0;
            3'd7: r = STATS ? 32'(m_drop) : 32'd0;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // One clock of the specified behaviour, applied to the model's state
    task automatic m_step(input logic wr, input logic rd, input logic [2:0] a, input logic [31:0] d,
                          input logic pd, input logic rdy, input logic [1:0] st);
        int n;
        logic pop, push;
        logic [2:0] set, clr;
        n = mq.size();
        pop = rdy && (n > 0);
        push = wr && (a == 3'd3);
        set = 3'b000;
        if (rd) m_rd = m_read(a);
        if (pd) set[0] = 1'b1;
        if (m_flush_pend) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                if (n == 4) begin
                    set[1] = 1'b1;
                    if (m_drop < 65535) m_drop++;
                end else begin
                    mq.push_back('{m_daddr, d});
                end
            end
            if (pop && n == 1 && mq.size() == 0) set[2] = 1'b1;
        end
        m_flush_pend = wr && (a == 3'd0) && d[1];
        if (wr && a == 3'd0) m_enable = d[0];
        if (wr && a == 3'd2) m_daddr = d;
        clr = (wr && a == 3'd4) ? d[2:0] : 3'b000;
        m_stat = (m_stat & ~clr) | set;
        if (wr && a == 3'd5) m_mask = d[2:0];
        m_irq = |(m_stat & m_mask);
        if (wr && a == 3'd6) m_pkt = 0;
        else if (pd && m_pkt < 65535) m_pkt++;
        if (wr && a == 3'd7) m_drop = 0;
        m_state = st;
    endtask

    // ---------------- register table ----------------
    typedef struct { logic [2:0] addr; logic [31:0] wdata; logic [31:0] exp; } vec_t;
    vec_t vecs[12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        bus.address = 3'd0; bus.writedata = 32'd0; bus.read = 1'b0; bus.write = 1'b0;

        // Reset state
        #3;
        check("rst_desc_valid", desc_valid, 0);
        check("rst_irq", irq, 0);
        check("rst_enable", enable, 0);
        check("rst_readdata", bus.readdata, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // Register write/read-back table (state mirror = 2)
        vecs[0]  = '{3'd0, 32'h0000_0001, 32'h0000_0001};
        vecs[1]  = '{3'd0, 32'hFFFF_FFFE, 32'h0000_0000};
        vecs[2]  = '{3'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[3]  = '{3'd3, 32'h0000_0040, 32'h0000_0000};
        vecs[4]  = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0102};
        vecs[5]  = '{3'd5, 32'hFFFF_FFF8, 32'h0000_0000};
        vecs[6]  = '{3'd5, 32'h0000_0005, 32'h0000_0005};
        vecs[7]  = '{3'd4, 32'h0000_0007, 32'h0000_0000};
        vecs[8]  = '{3'd6, 32'h0000_1234, 32'h0000_0000};
        vecs[9]  = '{3'd7, 32'h0000_0001, 32'h0000_0000};
        vecs[10] = '{3'd2, 32'h0000_0000, 32'h0000_0000};
        vecs[11] = '{3'd5, 32'hFFFF_FFFF, 32'h0000_0007};
        state = 2'd2;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            bus_write(vecs[i].addr, vecs[i].wdata);
            bus_read(vecs[i].addr, d);
            check($sformatf("table[%0d]@%0d", i, vecs[i].addr), d, vecs[i].exp);
        end
        check("table_head_addr", desc_addr, 32'hDEAD_BEEF);
        check("table_head_len", desc_len, 32'h40);

        // 1: async reset mid-operation
        do_reset();
        bus_write(3'd5, 32'h1);
        bus_write(3'd2, 32'hA0);
        bus_write(3'd3, 32'h1);
        bus_write(3'd3, 32'h2);
        pkt_done = 1'b1; @(negedge clk); pkt_done = 1'b0;
        check("t1_valid_before", desc_valid, 1);
        check("t1_irq_before", irq, 1);
        #2 reset = 1'b1;
        #1;
        check("t1_valid_async", desc_valid, 0);
        check("t1_irq_async", irq, 0);
        @(negedge clk);
        reset = 1'b0;
        read_check("t1_status", 3'd1, 32'h08);
        read_check("t1_mask", 3'd5, 32'h0);

        // 2: queue fill and overflow
        do_reset();
        bus_write(3'd2, 32'h1000);
        for (int i = 0; i < 4; i++) bus_write(3'd3, 32'd64);
        read_check("t2_status_full", 3'd1, 32'h404);
        check("t2_head_addr", desc_addr, 32'h1000);
        check("t2_head_len", desc_len, 32'd64);
        bus_write(3'd3, 32'd64);
        read_check("t2_irq_ovf", 3'd4, 32'h2);
        read_check("t2_drop_cnt", 3'd7, STATS ? 32'd1 : 32'd0);
        read_check("t2_status_still_full", 3'd1, 32'h404);
        bus_write(3'd7, 32'd0);
        read_check("t2_drop_clear", 3'd7, 32'd0);

        // 3: pop order across pointer wrap, drain interrupt
        do_reset();
        desc_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) bus_write(3'd4, 32'h7);
            bus_write(3'd2, 32'hA000_0000 + 32'(i) * 32'h100);
            bus_write(3'd3, 32'(i + 1));
            check($sformatf("t3_valid[%0d]", i), desc_valid, 1);
            check($sformatf("t3_addr[%0d]", i), desc_addr, 32'hA000_0000 + 32'(i) * 32'h100);
            check($sformatf("t3_len[%0d]", i), desc_len, 32'(i + 1));
            @(negedge clk);
            check($sformatf("t3_popped[%0d]", i), desc_valid, 0);
        end
        read_check("t3_drained", 3'd4, 32'h4);
        desc_ready = 1'b0;

        // 4: interrupt set, clear, and set-beats-clear
        do_reset();
        bus_write(3'd5, 32'h1);
        pkt_done = 1'b1; @(negedge clk); pkt_done = 1'b0;
        check("t4_irq_set", irq, 1);
        read_check("t4_stat", 3'd4, 32'h1);
        bus_write(3'd4, 32'h1);
        check("t4_irq_cleared", irq, 0);
        pkt_done = 1'b1;
        bus_write(3'd4, 32'h1);
        pkt_done = 1'b0;
        check("t4_irq_set_wins", irq, 1);
        read_check("t4_stat_set_wins", 3'd4, 32'h1);
        read_check("t4_pkt_cnt", 3'd6, STATS ? 32'd2 : 32'd0);
        bus_write(3'd5, 32'h0);
        check("t4_irq_masked", irq, 0);

        // 5: read/write collision and read latency
        do_reset();
        bus.address = 3'd0; bus.writedata = 32'h1; bus.write = 1'b1; bus.read = 1'b1;
        @(negedge clk);
        bus.write = 1'b0; bus.read = 1'b0;
        check("t5_collide_old", bus.readdata, 0);
        check("t5_enable", enable, 1);
        read_check("t5_ctrl_new", 3'd0, 32'h1);
        bus_write(3'd2, 32'h55);
        bus_write(3'd3, 32'h77);
        read_check("t5_len_wo", 3'd3, 32'h0);
        read_check("t5_addr", 3'd2, 32'h55);
        @(negedge clk); @(negedge clk);
        check("t5_hold", bus.readdata, 32'h55);

        // 6: flush with a push in the flush cycle
        do_reset();
        bus_write(3'd0, 32'h1);
        for (int i = 0; i < 3; i++) begin
            bus_write(3'd2, 32'hC0 + 32'(i));
            bus_write(3'd3, 32'h10);
        end
        read_check("t6_status3", 3'd1, 32'h300);
        bus_write(3'd0, 32'h3);
        bus_write(3'd3, 32'h99);
        check("t6_valid", desc_valid, 0);
        check("t6_enable", enable, 1);
        read_check("t6_status0", 3'd1, 32'h08);
        read_check("t6_ctrl", 3'd0, 32'h1);
        read_check("t6_irq_stat", 3'd4, 32'h0);

        // Randomized traffic against the model
        do_reset();
        m_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic wr, rd, pd, rdy;
            logic [2:0] a;
            logic [31:0] dw;
            logic [1:0] st;
            int op;
            check("rnd_valid", desc_valid, (mq.size() > 0) ? 32'd1 : 32'd0);
            if (mq.size() > 0) begin
                check("rnd_addr", desc_addr, mq[0].addr);
                check("rnd_len", desc_len, mq[0].len);
            end
            check("rnd_irq", irq, m_irq);
            check("rnd_enable", enable, m_enable);
            check("rnd_readdata", bus.readdata, m_rd);

            op = $urandom_range(0, 11);
            wr = 1'b1;
            dw = $urandom();
            a = 3'($urandom_range(0, 7));
            case (op)
                0, 1:       a = 3'd2;
                2, 3, 4, 5: a = 3'd3;
                6:          a = 3'd4;
                7:          a = 3'd5;
                8: begin
                    a = 3'd0;
                    dw[1] = ($urandom_range(0, 5) == 0);
                end
                9:          a = 3'($urandom_range(6, 7));
                default:    wr = 1'b0;
            endcase
            rd  = ($urandom_range(0, 2) == 0);
            pd  = ($urandom_range(0, 3) == 0) && !(wr && a == 3'd6);
            rdy = 1'($urandom_range(0, 1));
            st  = 2'($urandom_range(0, 3));

            bus.address = a; bus.writedata = dw; bus.write = wr; bus.read = rd;
            pkt_done = pd; desc_ready = rdy; state = st;
            m_step(wr, rd, a, dw, pd, rdy, st);
            @(negedge clk);
        end
        bus.write = 1'b0; bus.read = 1'b0; pkt_done = 1'b0; desc_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
